instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage for the single-cycle MIPS core on the Nexys4 DDR. It holds the program counter and fetches each instruction from instruction memory through a request/acknowledge handshake. It presents the instruction for one execute cycle to the control unit and datapath, then computes the next PC from the branch (PCSrc) and jump (Jump) decisions made during that cycle. It also supports free-run and single-step operation for board debugging, and counts retired instructions.

## Interface
- PC_WIDTH, 32, width of PC and instruction-memory address
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = fetch/execute continuously
- step  in  1  one-cycle pulse (debounced externally); executes exactly one instruction when run=0
- PCSrc  in  1  branch taken, from control unit; sampled only in EXEC
- Jump  in  1  jump, from control unit; sampled only in EXEC
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_WIDTH  byte address of fetch, equals pc
- imem_rdata  in  INSTR_WIDTH  instruction data; valid when imem_ack=1
- imem_ack  in  1  fetch complete; may arrive in the same cycle as imem_req or any later cycle
- instr  out  INSTR_WIDTH  registered current instruction; OpCode = instr[31:26], Funct = instr[5:0]
- pc  out  PC_WIDTH  address of current instruction
- pc_plus4  out  PC_WIDTH  pc + 4, combinational
- instr_valid  out  1  execute strobe; datapath commits register/memory writes only while high
- instr_count  out  32  retired-instruction counter

## Operation
- FSM states: IDLE, FETCH, EXEC. Moore outputs: imem_req = (state==FETCH), instr_valid = (state==EXEC). imem_addr = pc at all times.
- IDLE: if run=1 → FETCH. Else if step=1 → FETCH. Else remain in IDLE. A step pulse while run=1, or in any state other than IDLE, is ignored.
- FETCH: hold imem_req=1 with imem_addr stable until imem_ack=1. On ack: instr ← imem_rdata, → EXEC.
- EXEC: lasts exactly one cycle. At the end of the cycle:
  - pc ← next PC.
  - instr_count ← instr_count + 1, wrapping modulo 2^32.
  - Go to FETCH if run=1, else IDLE.
- Next PC, with Jump taking priority over PCSrc:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else PCSrc=1: pc_plus4 + {sign-extend(instr[15:0]), 2'b00}
  - else: pc_plus4
- All PC arithmetic is modulo 2^PC_WIDTH. 32'hFFFF_FFFC + 4 = 32'h0000_0000. Negative branch offsets wrap identically.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on ack in FETCH.
- instr holds its value outside the ack capture, so control-unit inputs stay stable through IDLE.
- run falling during FETCH: the fetch completes, EXEC executes, then the FSM goes to IDLE. Instructions are never abandoned mid-flight except by reset.
- Reset, at any state including mid-fetch: the FSM goes immediately to IDLE and imem_req drops asynchronously. Any pending memory response is discarded.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instr_count=0. pc_plus4=RESET_PC+4.
- Start latency: run/step sampled high in IDLE at edge N → imem_req=1 in cycle N+1.
- Fetch latency: imem_ack high in cycle M → instr updated and instr_valid=1 in cycle M+1, for one cycle.
- Zero-wait memory (ack in the same cycle as req): one instruction per 2 cycles. W wait states: one per W+2 cycles.
- The pc update and the instr_count increment occur at the same edge that ends EXEC. The new pc is visible on imem_addr in the following FETCH cycle.
- PCSrc and Jump must be settled from instr within the EXEC cycle. They are combinational from instr via the control unit.

## Test plan
- Reset: assert rst_n=0 mid-FETCH with imem_req=1 → imem_req=0 immediately. pc=0, instr=0, instr_count=0. After release, FSM stays in IDLE while run=0 and step=0.
- Free run, zero-wait ROM of four R-type instructions: run=1 → imem_addr sequence 0,4,8,C. instr_valid pulses every 2nd cycle. instr_count=4 after 8 cycles.
- Branch: instr at pc=0x10 with instr[15:0]=16'hFFFE, PCSrc=1 in EXEC → next pc=0x0C. Same instr with PCSrc=0 → pc=0x14.
- Jump priority: instr=32'h0800_0040 at pc=0x20, Jump=1 and PCSrc=1 → next pc=0x100.
- Wait states and single step: run=0, step pulse, ack after 3 cycles → exactly one instr_valid pulse, then IDLE. A second step during FETCH is ignored. pc=4, instr_count=1.
- Wrap: RESET_PC=32'hFFFF_FFFC, run=1, non-branch instr → second fetch address 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, request/acknowledge instruction fetch,
// one-cycle execute strobe, next-PC selection and retired-instruction counter.
module instr_fetch_unit #(
    parameter int unsigned              PC_WIDTH    = 32,
    parameter int unsigned              INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]      RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   PCSrc,
    input  logic                   Jump,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ack,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    output logic                   instr_valid,
    output logic [31:0]            instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [31:0]              count_q, count_d;
    logic [PC_WIDTH-1:0]      branch_off;
    logic [PC_WIDTH-1:0]      next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // step is only honoured from IDLE; run has priority there anyway
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run || step) state_d = FETCH;
            FETCH:   if (imem_ack)    state_d = EXEC;
            EXEC:    state_d = run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH);
        instr_valid = (state_q == EXEC);
    end

    assign pc_plus4   = pc_q + PC_WIDTH'(4);
    assign branch_off = {{(PC_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        if (Jump) begin
            next_pc = {pc_plus4[PC_WIDTH-1:28], instr_q[25:0], 2'b00};
        end else if (PCSrc) begin
            next_pc = pc_plus4 + branch_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        if (state_q == FETCH && imem_ack) begin
            instr_d = imem_rdata;
        end
        if (state_q == EXEC) begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_count = count_q;

endmodule
